// File: rtl/read_bpm_test_link.sv
`default_nettype none
// ============================================================================
// Module   : read_bpm_test_link
// Brief    : Receive-side checker for the BPM test link. Checks each
//            four-word test packet (header, X, Y, sum) against the expected
//            pattern. Reports one status code per FA session and keeps
//            good-packet and error-session counters.
// Revision : 1.0 - initial release
// ============================================================================
module read_bpm_test_link #(
    parameter int BPM_COUNT        = 16,
    parameter int CELL_INDEX       = 12,
    parameter int BPM_GLOBAL_INDEX = 2
) (
    input  logic        auroraUserClk,
    input  logic        auroraResetN,
    input  logic        auroraFAstrobe,
    input  logic        auroraChannelUp,
    input  logic [31:0] BPM_TEST_AXI_STREAM_RX_tdata,
    input  logic        BPM_TEST_AXI_STREAM_RX_tvalid,
    input  logic        BPM_TEST_AXI_STREAM_RX_tlast,
    output logic        BPM_TEST_AXI_STREAM_RX_tready,
    output logic        TESTstatusStrobe,
    output logic [1:0]  TESTstatusCode,
    output logic [15:0] packetCount,
    output logic [15:0] errorCount,
    output logic [2:0]  dbgRxState
);

    // Receive FSM encoding (the values are visible on dbgRxState)
    localparam logic [2:0] c_RX_HEADER  = 3'd0;
    localparam logic [2:0] c_RX_X       = 3'd1;
    localparam logic [2:0] c_RX_Y       = 3'd2;
    localparam logic [2:0] c_RX_S       = 3'd3;
    localparam logic [2:0] c_RX_DISCARD = 3'd4;

    // Session status codes
    localparam logic [1:0] c_CODE_OK      = 2'd0;
    localparam logic [1:0] c_CODE_CONTENT = 2'd1;
    localparam logic [1:0] c_CODE_FRAMING = 2'd2;
    localparam logic [1:0] c_CODE_COUNT   = 2'd3;

    localparam logic [4:0]  c_CELL    = CELL_INDEX[4:0];
    localparam logic [3:0]  c_PREFIX  = BPM_GLOBAL_INDEX[3:0];
    localparam logic [6:0]  c_COUNT   = BPM_COUNT[6:0];
    localparam logic [6:0]  c_IDX_MAX = 7'h7F;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Receive state and per-session bookkeeping
    logic [2:0]  r_rxState;
    logic [6:0]  r_pktIdx;
    logic        r_framing;
    logic        r_content;
    logic        r_overflow;
    logic        r_linkDown;
    logic        r_pktBad;
    logic        r_sessionOpen;

    // Session cycle counter tracking
    logic [15:0] r_c;
    logic        r_cValid;
    logic        r_cSeen;

    // Outputs and counters
    logic        r_goodPulse;
    logic        r_statusStrobe;
    logic [1:0]  r_statusCode;
    logic [15:0] r_packetCount;
    logic [15:0] r_errorCount;

    // Combinational decode
    logic        w_beat;
    logic        w_sBeat;
    logic [4:0]  w_idx5;
    logic [31:0] w_expHeader;
    logic [31:0] w_expX;
    logic [31:0] w_expY;
    logic [15:0] w_expC;
    logic        w_sIdxOk;
    logic        w_sCOk;
    logic [2:0]  w_nextState;
    logic        w_wordBad;
    logic        w_framingBeat;
    logic        w_sComplete;
    logic [6:0]  w_pktIdxNext;
    logic        w_overflowNext;
    logic        w_framingNext;
    logic        w_contentNext;
    logic        w_linkDownNext;
    logic        w_pktGood;
    logic        w_close;
    logic [1:0]  w_closeCode;

    // The checker never back-pressures; ready simply follows reset
    assign BPM_TEST_AXI_STREAM_RX_tready = auroraResetN;

    assign w_beat  = BPM_TEST_AXI_STREAM_RX_tvalid && BPM_TEST_AXI_STREAM_RX_tready;
    assign w_sBeat = w_beat && (r_rxState == c_RX_S);
    assign w_idx5  = r_pktIdx[4:0];

    assign w_expHeader = {16'hA5BE, 1'b1, c_CELL, 1'b0, c_PREFIX, w_idx5};
    assign w_expX      = {16'hCAFE, 11'b0, w_idx5};
    assign w_expY      = {16'hBEEF, 11'b0, w_idx5};

    // First S of a session expects the previous C plus one; later S words repeat it
    assign w_expC   = r_cSeen ? r_c : (r_c + 16'd1);
    assign w_sIdxOk = (BPM_TEST_AXI_STREAM_RX_tdata[15:0] == {11'b0, w_idx5});
    assign w_sCOk   = !r_cValid || (BPM_TEST_AXI_STREAM_RX_tdata[31:16] == w_expC);

    // Next-state, word check and framing decode for the current beat
    always_comb begin
        w_nextState   = r_rxState;
        w_wordBad     = 1'b0;
        w_framingBeat = 1'b0;
        w_sComplete   = 1'b0;
        if (w_beat) begin
            case (r_rxState)
                c_RX_HEADER: begin
                    w_wordBad = (BPM_TEST_AXI_STREAM_RX_tdata != w_expHeader);
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_framingBeat = 1'b1;
                        w_nextState   = c_RX_HEADER;
                    end else begin
                        w_nextState = c_RX_X;
                    end
                end
                c_RX_X: begin
                    w_wordBad = (BPM_TEST_AXI_STREAM_RX_tdata != w_expX);
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_framingBeat = 1'b1;
                        w_nextState   = c_RX_HEADER;
                    end else begin
                        w_nextState = c_RX_Y;
                    end
                end
                c_RX_Y: begin
                    w_wordBad = (BPM_TEST_AXI_STREAM_RX_tdata != w_expY);
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_framingBeat = 1'b1;
                        w_nextState   = c_RX_HEADER;
                    end else begin
                        w_nextState = c_RX_S;
                    end
                end
                c_RX_S: begin
                    w_wordBad = !(w_sIdxOk && w_sCOk);
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_sComplete = 1'b1;
                        w_nextState = c_RX_HEADER;
                    end else begin
                        // Packet runs on past its sum word: resync on the next tlast
                        w_framingBeat = 1'b1;
                        w_nextState   = c_RX_DISCARD;
                    end
                end
                c_RX_DISCARD: begin
                    if (BPM_TEST_AXI_STREAM_RX_tlast) begin
                        w_nextState = c_RX_HEADER;
                    end
                end
                default: begin
                    w_nextState = c_RX_HEADER;
                end
            endcase
        end
    end

    // Flag and index values including this cycle's beat, used both for update and close
    assign w_pktIdxNext   = (w_sComplete && (r_pktIdx != c_IDX_MAX)) ? (r_pktIdx + 7'd1) : r_pktIdx;
    assign w_overflowNext = r_overflow || (w_sComplete && (r_pktIdx >= c_COUNT));
    assign w_linkDownNext = r_linkDown || !auroraChannelUp;
    assign w_contentNext  = r_content || w_wordBad;
    // A strobe arriving with a packet still in flight cuts it off
    assign w_framingNext  = r_framing || w_framingBeat || !auroraChannelUp
                         || (auroraFAstrobe && (w_nextState != c_RX_HEADER));
    assign w_pktGood      = w_sComplete && !r_pktBad && !w_wordBad;
    assign w_close        = auroraFAstrobe && r_sessionOpen;

    // Session result with framing > content > count > OK priority
    always_comb begin
        w_closeCode = c_CODE_OK;
        if (w_framingNext) begin
            w_closeCode = c_CODE_FRAMING;
        end else if (w_contentNext) begin
            w_closeCode = c_CODE_CONTENT;
        end else if ((w_pktIdxNext != c_COUNT) || w_overflowNext) begin
            w_closeCode = c_CODE_COUNT;
        end
    end

    // Receive FSM, packet index and session flags; the FA strobe restarts the session
    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) begin
            r_rxState     <= c_RX_HEADER;
            r_pktIdx      <= 7'd0;
            r_framing     <= 1'b0;
            r_content     <= 1'b0;
            r_overflow    <= 1'b0;
            r_linkDown    <= 1'b0;
            r_pktBad      <= 1'b0;
            r_sessionOpen <= 1'b0;
        end else if (auroraFAstrobe) begin
            r_rxState     <= c_RX_HEADER;
            r_pktIdx      <= 7'd0;
            r_framing     <= 1'b0;
            r_content     <= 1'b0;
            r_overflow    <= 1'b0;
            r_linkDown    <= 1'b0;
            r_pktBad      <= 1'b0;
            r_sessionOpen <= 1'b1;
        end else begin
            r_rxState  <= w_nextState;
            r_pktIdx   <= w_pktIdxNext;
            r_framing  <= w_framingNext;
            r_content  <= w_contentNext;
            r_overflow <= w_overflowNext;
            r_linkDown <= w_linkDownNext;
            if (w_beat && (r_rxState == c_RX_HEADER)) begin
                r_pktBad <= w_wordBad;
            end else if (w_beat) begin
                r_pktBad <= r_pktBad || w_wordBad;
            end
        end
    end

    // Session cycle counter: capture when unknown, otherwise advance to the expected value
    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) begin
            r_c      <= 16'd0;
            r_cValid <= 1'b0;
            r_cSeen  <= 1'b0;
        end else begin
            if (w_sBeat) begin
                r_c      <= r_cValid ? w_expC : BPM_TEST_AXI_STREAM_RX_tdata[31:16];
                r_cValid <= 1'b1;
                r_cSeen  <= 1'b1;
            end
            if (auroraFAstrobe) begin
                r_cSeen <= 1'b0;
                // A link drop makes the counter continuity untrustworthy: recapture
                if (!r_sessionOpen || w_linkDownNext) begin
                    r_cValid <= 1'b0;
                end
            end
        end
    end

    // Status strobe, held status code and saturating error-session counter
    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) begin
            r_statusStrobe <= 1'b0;
            r_statusCode   <= c_CODE_OK;
            r_errorCount   <= 16'd0;
        end else begin
            r_statusStrobe <= w_close;
            if (w_close) begin
                r_statusCode <= w_closeCode;
                if ((w_closeCode != c_CODE_OK) && (r_errorCount != c_CNT_MAX)) begin
                    r_errorCount <= r_errorCount + 16'd1;
                end
            end
        end
    end

    // Good-packet counter, updated the cycle after the completing sum word
    always_ff @(posedge auroraUserClk) begin
        if (!auroraResetN) begin
            r_goodPulse   <= 1'b0;
            r_packetCount <= 16'd0;
        end else begin
            r_goodPulse <= w_pktGood;
            if (r_goodPulse && (r_packetCount != c_CNT_MAX)) begin
                r_packetCount <= r_packetCount + 16'd1;
            end
        end
    end

    assign TESTstatusStrobe = r_statusStrobe;
    assign TESTstatusCode   = r_statusCode;
    assign packetCount      = r_packetCount;
    assign errorCount       = r_errorCount;
    assign dbgRxState       = r_rxState;

endmodule
`default_nettype wire

// File: tb/tb_read_bpm_test_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_bpm_test_link
// Brief    : Scoreboard bench for read_bpm_test_link. Stimulus builds whole
//            sessions of test packets and predicts each session result.
//            A monitor compares the result whenever the status strobe fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_bpm_test_link;

    localparam int BPM_COUNT        = 16;
    localparam int CELL_INDEX       = 12;
    localparam int BPM_GLOBAL_INDEX = 2;

    logic        auroraUserClk = 1'b0;
    logic        auroraResetN  = 1'b0;
    logic        auroraFAstrobe = 1'b0;
    logic        auroraChannelUp = 1'b1;
    logic [31:0] tdata  = 32'd0;
    logic        tvalid = 1'b0;
    logic        tlast  = 1'b0;
    logic        tready;
    logic        TESTstatusStrobe;
    logic [1:0]  TESTstatusCode;
    logic [15:0] packetCount;
    logic [15:0] errorCount;
    logic [2:0]  dbgRxState;

    always #5 auroraUserClk = ~auroraUserClk;

    read_bpm_test_link #(
        .BPM_COUNT        (BPM_COUNT),
        .CELL_INDEX       (CELL_INDEX),
        .BPM_GLOBAL_INDEX (BPM_GLOBAL_INDEX)
    ) dut (
        .auroraUserClk                 (auroraUserClk),
        .auroraResetN                  (auroraResetN),
        .auroraFAstrobe                (auroraFAstrobe),
        .auroraChannelUp               (auroraChannelUp),
        .BPM_TEST_AXI_STREAM_RX_tdata  (tdata),
        .BPM_TEST_AXI_STREAM_RX_tvalid (tvalid),
        .BPM_TEST_AXI_STREAM_RX_tlast  (tlast),
        .BPM_TEST_AXI_STREAM_RX_tready (tready),
        .TESTstatusStrobe              (TESTstatusStrobe),
        .TESTstatusCode                (TESTstatusCode),
        .packetCount                   (packetCount),
        .errorCount                    (errorCount),
        .dbgRxState                    (dbgRxState)
    );

    typedef struct {
        int code;
        int errCnt;
        int pktCnt;
    } exp_t;

    exp_t expQ[$];
    int   passCount  = 0;
    int   checkCount = 0;

    // Reference model state
    int m_c        = 0;
    bit m_cValid   = 1'b0;
    int m_pktCount = 0;
    int m_errCount = 0;

    task automatic check(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    function automatic logic [31:0] hdrW(input int i);
        return 32'hA5BE8000 | 32'((CELL_INDEX % 32) << 10) | 32'((BPM_GLOBAL_INDEX % 16) << 5) | 32'(i % 32);
    endfunction
    function automatic logic [31:0] xW(input int i);
        return 32'hCAFE0000 | 32'(i % 32);
    endfunction
    function automatic logic [31:0] yW(input int i);
        return 32'hBEEF0000 | 32'(i % 32);
    endfunction
    function automatic logic [31:0] sW(input int c, input int i);
        return (32'(c % 65536) << 16) | 32'(i % 32);
    endfunction

    // One clock cycle of input drive, applied at the falling edge
    task automatic cyc(input bit v, input logic [31:0] d, input bit l, input bit fa, input bit up);
        @(negedge auroraUserClk);
        tvalid          = v;
        tdata           = d;
        tlast           = l;
        auroraFAstrobe  = fa;
        auroraChannelUp = up;
    endtask

    task automatic beat(input logic [31:0] d, input bit l, input bit fa);
        int gaps;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) cyc(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, d, l, fa, 1'b1);
    endtask

    // Drive one FA session and predict its result.
    //   abortKind 0: extra partial packet with tlast on word abortWord
    //   abortKind 1: extra packet whose S word lacks tlast, then one junk tlast beat
    task automatic run_session(input int nPkts, input int freshC, input int cDelta,
                               input int abortPkt, input int abortKind, input int abortWord,
                               input int corruptPkt, input int dropPkt, input bit faWithLast);
        bit framing;
        bit content;
        int good;
        int cVal;
        int code;
        int wsel;
        int bsel;
        bit bad;
        logic [31:0] w [4];
        framing = 1'b0;
        content = 1'b0;
        good    = 0;
        if (m_cValid) begin
            m_c = (m_c + 1) % 65536;
        end else begin
            m_c      = (freshC >= 0) ? freshC : int'($urandom_range(0, 65535));
            m_cValid = 1'b1;
            cDelta   = 0;
        end
        cVal = (m_c + cDelta) % 65536;
        for (int p = 0; p < nPkts; p++) begin
            w[0] = hdrW(p);
            w[1] = xW(p);
            w[2] = yW(p);
            w[3] = sW(cVal, p);
            if (p == dropPkt) begin
                cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
                framing = 1'b1;
            end
            if (p == abortPkt) begin
                framing = 1'b1;
                if (abortKind == 0) begin
                    for (int k = 0; k <= abortWord; k++) beat(w[k], k == abortWord, 1'b0);
                end else begin
                    for (int k = 0; k < 4; k++) beat(w[k], 1'b0, 1'b0);
                    beat($urandom, 1'b1, 1'b0);
                end
            end
            bad = (cDelta != 0);
            if (p == corruptPkt) begin
                wsel = int'($urandom_range(0, 3));
                bsel = (wsel == 3) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31));
                w[wsel] = w[wsel] ^ (32'd1 << bsel);
                bad = 1'b1;
            end
            if (bad) content = 1'b1;
            for (int k = 0; k < 4; k++)
                beat(w[k], k == 3, faWithLast && (k == 3) && (p == nPkts - 1));
            if (!bad) good++;
        end
        if (framing)                 code = 2;
        else if (content)            code = 1;
        else if (nPkts != BPM_COUNT) code = 3;
        else                         code = 0;
        m_pktCount = (m_pktCount + good > 65535) ? 65535 : m_pktCount + good;
        if (code != 0 && m_errCount < 65535) m_errCount++;
        expQ.push_back('{code, m_errCount, m_pktCount});
        if (!faWithLast) begin
            cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        end
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        if (dropPkt >= 0) m_cValid = 1'b0;
    endtask

    // Monitor: every status strobe is matched against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge auroraUserClk);
            if (TESTstatusStrobe === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    check("status_code", int'(TESTstatusCode), e.code);
                    check("error_count", int'(errorCount), e.errCnt);
                    @(negedge auroraUserClk);
                    check("strobe_width", int'(TESTstatusStrobe), 0);
                    check("packet_count", int'(packetCount), e.pktCnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int nP;
        int cp;
        int ap;
        repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("reset_tready", int'(tready), 0);
        check("reset_strobe", int'(TESTstatusStrobe), 0);
        check("reset_code", int'(TESTstatusCode), 0);
        check("reset_pktcnt", int'(packetCount), 0);
        check("reset_errcnt", int'(errorCount), 0);
        check("reset_state", int'(dbgRxState), 0);
        @(negedge auroraUserClk);
        auroraResetN = 1'b1;
        #1;
        check("run_tready", int'(tready), 1);

        // Opening strobe: no result expected
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);

        run_session(16, 5, 0, -1, 0, 0, -1, -1, 1'b0);   // clean, C=0x0005
        run_session(16, -1, 1, -1, 0, 0, -1, -1, 1'b0);  // C+2 instead of C+1
        run_session(16, -1, 0, 3, 0, 2, -1, -1, 1'b0);   // early tlast on Y of packet 3
        run_session(15, -1, 0, -1, 0, 0, -1, -1, 1'b0);  // short session
        run_session(17, -1, 0, -1, 0, 0, -1, -1, 1'b0);  // overflow session
        run_session(16, -1, 0, -1, 0, 0, -1, 5, 1'b0);   // link drop
        run_session(16, -1, 0, -1, 0, 0, -1, -1, 1'b1);  // recapture, strobe on last S

        for (int r = 0; r < 4; r++) begin
            nP = int'($urandom_range(15, 17));
            cp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nP - 1)) : -1;
            ap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nP - 1)) : -1;
            run_session(nP, -1, 0, ap, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                        cp, -1, bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a packet
        repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        beat(hdrW(0), 1'b0, 1'b0);
        beat(xW(0), 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("midpkt_state", int'(dbgRxState), 2);
        auroraResetN = 1'b0;
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("midrst_tready", int'(tready), 0);
        check("midrst_strobe", int'(TESTstatusStrobe), 0);
        check("midrst_code", int'(TESTstatusCode), 0);
        check("midrst_pktcnt", int'(packetCount), 0);
        check("midrst_errcnt", int'(errorCount), 0);
        check("midrst_state", int'(dbgRxState), 0);
        m_pktCount = 0;
        m_errCount = 0;
        m_cValid   = 1'b0;
        @(negedge auroraUserClk);
        auroraResetN = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        run_session(16, -1, 0, -1, 0, 0, -1, -1, 1'b0);

        repeat (6) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("pending_results", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
